// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Decode-to-execute instruction bus. Carries one decoded
//               instruction (valid flag, PC, operands, immediate, register
//               indices, ALU opcode, operand selects and control bits) from
//               the decode stage into the ID/EX pipeline register.
// Modports    : master - decode stage, drives every field
//               slave  - id_ex_stage, samples every field
// Parameters  : DATA_WIDTH, OPCODE_LENGTH, REG_ADDR_WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      id_valid;
    logic [DATA_WIDTH-1:0]     id_pc;
    logic [DATA_WIDTH-1:0]     id_rs1_data;
    logic [DATA_WIDTH-1:0]     id_rs2_data;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic [OPCODE_LENGTH-1:0]  id_alu_op;
    logic                      id_asel;
    logic                      id_bsel;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic                      id_mem_write;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_op, id_asel, id_bsel,
               id_reg_write, id_mem_read, id_mem_write
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_op, id_asel, id_bsel,
               id_reg_write, id_mem_read, id_mem_write
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register and ALU operand-select stage.
//               Captures one decoded instruction per cycle, resolves operand
//               forwarding from the MEM and WB stages combinationally in the
//               EX cycle, drives SrcA/SrcB/Operation to the ALU and detects
//               load-use hazards, inserting a single bubble per hazard.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               id_bus (slave)    - decoded instruction from the ID stage
//               flush             - kill the instruction entering EX
//               mem_rd/_reg_write/_result - EX/MEM forwarding source
//               wb_rd/_reg_write/_result  - MEM/WB forwarding source
//               load_use_stall    - upstream holds PC and IF/ID this cycle
//               ex_valid, SrcA, SrcB, Operation, ex_store_data,
//               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write - EX outputs
// Options     : `define ID_EX_PERF_EN adds a saturating 32-bit output
//               bubble_cnt counting load-use bubbles (flushes not counted).
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    id_ex_stage_if.slave                   id_bus,
    input  wire logic                      flush,
    input  wire logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  wire logic                      mem_reg_write,
    input  wire logic [DATA_WIDTH-1:0]     mem_result,
    input  wire logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  wire logic                      wb_reg_write,
    input  wire logic [DATA_WIDTH-1:0]     wb_result,
    output logic                           load_use_stall,
    output logic                           ex_valid,
    output logic [DATA_WIDTH-1:0]          SrcA,
    output logic [DATA_WIDTH-1:0]          SrcB,
    output logic [OPCODE_LENGTH-1:0]       Operation,
    output logic [DATA_WIDTH-1:0]          ex_store_data,
    output logic [REG_ADDR_WIDTH-1:0]      ex_rd,
    output logic                           ex_reg_write,
    output logic                           ex_mem_read,
    output logic                           ex_mem_write
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]                    bubble_cnt
`endif
);

    localparam logic [REG_ADDR_WIDTH-1:0] c_x0 = '0;

    // ------------------------------------------------------------------
    // EX pipeline register
    // ------------------------------------------------------------------
    logic                      r_valid;
    logic [DATA_WIDTH-1:0]     r_pc;
    logic [DATA_WIDTH-1:0]     r_rs1_data;
    logic [DATA_WIDTH-1:0]     r_rs2_data;
    logic [DATA_WIDTH-1:0]     r_imm;
    logic [REG_ADDR_WIDTH-1:0] r_rs1;
    logic [REG_ADDR_WIDTH-1:0] r_rs2;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [OPCODE_LENGTH-1:0]  r_alu_op;
    logic                      r_asel;
    logic                      r_bsel;
    logic                      r_reg_write;
    logic                      r_mem_read;
    logic                      r_mem_write;

    logic                      w_stall;
    logic                      w_bubble;
    logic                      w_src_hit;
    logic [DATA_WIDTH-1:0]     w_fwd_rs1;
    logic [DATA_WIDTH-1:0]     w_fwd_rs2;

    // ------------------------------------------------------------------
    // Load-use hazard: the load in EX has no data until MEM, so a
    // dependent instruction in ID must wait one cycle. A flush kills the
    // ID instruction anyway, so it suppresses the stall.
    // ------------------------------------------------------------------
    assign w_src_hit = (id_bus.id_rs1 == r_rd) || (id_bus.id_rs2 == r_rd);

    assign w_stall = r_valid && r_mem_read && (r_rd != c_x0) &&
                     id_bus.id_valid && w_src_hit && !flush;

    assign load_use_stall = w_stall;

    assign w_bubble = flush || w_stall || !id_bus.id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_alu_op    <= '0;
            r_asel      <= 1'b0;
            r_bsel      <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (w_bubble) begin
            // A bubble is indistinguishable from the reset state so that
            // downstream stages never see stale indices or control bits.
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_alu_op    <= '0;
            r_asel      <= 1'b0;
            r_bsel      <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_valid     <= 1'b1;
            r_pc        <= id_bus.id_pc;
            r_rs1_data  <= id_bus.id_rs1_data;
            r_rs2_data  <= id_bus.id_rs2_data;
            r_imm       <= id_bus.id_imm;
            r_rs1       <= id_bus.id_rs1;
            r_rs2       <= id_bus.id_rs2;
            r_rd        <= id_bus.id_rd;
            r_alu_op    <= id_bus.id_alu_op;
            r_asel      <= id_bus.id_asel;
            r_bsel      <= id_bus.id_bsel;
            r_reg_write <= id_bus.id_reg_write;
            r_mem_read  <= id_bus.id_mem_read;
            r_mem_write <= id_bus.id_mem_write;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding. MEM is checked first because it holds the younger
    // result. x0 is hardwired zero and is never forwarded.
    // ------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0]     rf_val,
        input logic [REG_ADDR_WIDTH-1:0] m_rd,
        input logic                      m_we,
        input logic [DATA_WIDTH-1:0]     m_val,
        input logic [REG_ADDR_WIDTH-1:0] w_rd,
        input logic                      w_we,
        input logic [DATA_WIDTH-1:0]     w_val
    );
        logic [DATA_WIDTH-1:0] sel;
        sel = rf_val;
        if (m_we && (m_rd != c_x0) && (m_rd == rs)) begin
            sel = m_val;
        end else if (w_we && (w_rd != c_x0) && (w_rd == rs)) begin
            sel = w_val;
        end
        return sel;
    endfunction

    always_comb begin
        w_fwd_rs1 = fwd_sel(r_rs1, r_rs1_data, mem_rd, mem_reg_write,
                            mem_result, wb_rd, wb_reg_write, wb_result);
        w_fwd_rs2 = fwd_sel(r_rs2, r_rs2_data, mem_rd, mem_reg_write,
                            mem_result, wb_rd, wb_reg_write, wb_result);
    end

    // ------------------------------------------------------------------
    // Operand select and downstream control
    // ------------------------------------------------------------------
    assign SrcA          = r_asel ? r_pc  : w_fwd_rs1;
    assign SrcB          = r_bsel ? r_imm : w_fwd_rs2;
    // Stores always need the register value, even when B carries the
    // address offset immediate.
    assign ex_store_data = w_fwd_rs2;
    assign Operation     = r_alu_op;
    assign ex_valid      = r_valid;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;

`ifdef ID_EX_PERF_EN
    // ------------------------------------------------------------------
    // Load-use bubble counter, saturating. Flush bubbles are excluded
    // because w_stall is already masked by flush.
    // ------------------------------------------------------------------
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_stall && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. Directed scenarios
//               followed by randomized traffic, all compared against a
//               transaction-level model of the EX register contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int OL = 4;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [RW-1:0] mem_rd;
    logic          mem_reg_write;
    logic [DW-1:0] mem_result;
    logic [RW-1:0] wb_rd;
    logic          wb_reg_write;
    logic [DW-1:0] wb_result;
    logic          load_use_stall;
    logic          ex_valid;
    logic [DW-1:0] SrcA;
    logic [DW-1:0] SrcB;
    logic [OL-1:0] Operation;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
`ifdef ID_EX_PERF_EN
    logic [31:0]   bubble_cnt;
`endif

    id_ex_stage_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .REG_ADDR_WIDTH(RW)) bus ();

    id_ex_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .REG_ADDR_WIDTH(RW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_bus         (bus.slave),
        .flush          (flush),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_result     (mem_result),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .wb_result      (wb_result),
        .load_use_stall (load_use_stall),
        .ex_valid       (ex_valid),
        .SrcA           (SrcA),
        .SrcB           (SrcB),
        .Operation      (Operation),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write)
`ifdef ID_EX_PERF_EN
        ,
        .bubble_cnt     (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model of what EX should hold: one decoded instruction, or all zero.
    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] rs1d;
        logic [DW-1:0] rs2d;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [RW-1:0] rd;
        logic [OL-1:0] op;
        logic          asel;
        logic          bsel;
        logic          rw;
        logic          mr;
        logic          mw;
    } ex_t;

    ex_t         m_ex;
    int unsigned m_cnt;
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value the ALU should see for a source register, by pipeline priority.
    function automatic logic [DW-1:0] m_operand(input logic [RW-1:0] rs, input logic [DW-1:0] rf);
        if (rs == 0)                            return rf;
        if (mem_reg_write && mem_rd == rs)      return mem_result;
        if (wb_reg_write && wb_rd == rs)        return wb_result;
        return rf;
    endfunction

    function automatic logic m_stall();
        logic dep;
        dep = (bus.id_rs1 == m_ex.rd) || (bus.id_rs2 == m_ex.rd);
        return m_ex.valid && m_ex.mr && (m_ex.rd != 0) && bus.id_valid && dep && !flush;
    endfunction

    task automatic check_all();
        logic [DW-1:0] a, b;
        a = m_ex.asel ? m_ex.pc  : m_operand(m_ex.rs1, m_ex.rs1d);
        b = m_ex.bsel ? m_ex.imm : m_operand(m_ex.rs2, m_ex.rs2d);
        chk("load_use_stall", DW'(load_use_stall), DW'(m_stall()));
        chk("ex_valid",       DW'(ex_valid),       DW'(m_ex.valid));
        chk("SrcA",           SrcA,                a);
        chk("SrcB",           SrcB,                b);
        chk("Operation",      DW'(Operation),      DW'(m_ex.op));
        chk("ex_store_data",  ex_store_data,       m_operand(m_ex.rs2, m_ex.rs2d));
        chk("ex_rd",          DW'(ex_rd),          DW'(m_ex.rd));
        chk("ex_reg_write",   DW'(ex_reg_write),   DW'(m_ex.rw));
        chk("ex_mem_read",    DW'(ex_mem_read),    DW'(m_ex.mr));
        chk("ex_mem_write",   DW'(ex_mem_write),   DW'(m_ex.mw));
`ifdef ID_EX_PERF_EN
        chk("bubble_cnt",     bubble_cnt,          DW'(m_cnt));
`endif
    endtask

    // Advance one clock, updating the model with what should be captured.
    task automatic tick();
        ex_t  nxt;
        logic st;
        st  = m_stall();
        nxt = '0;
        if (rst_n && bus.id_valid && !flush && !st) begin
            nxt = '{valid: 1'b1, pc: bus.id_pc, rs1d: bus.id_rs1_data,
                    rs2d: bus.id_rs2_data, imm: bus.id_imm, rs1: bus.id_rs1,
                    rs2: bus.id_rs2, rd: bus.id_rd, op: bus.id_alu_op,
                    asel: bus.id_asel, bsel: bus.id_bsel, rw: bus.id_reg_write,
                    mr: bus.id_mem_read, mw: bus.id_mem_write};
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_ex = nxt;
            if (st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end else begin
            m_ex  = '0;
            m_cnt = 0;
        end
    endtask

    task automatic drive_id(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                            input logic [RW-1:0] rd, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                            input logic [OL-1:0] op, input logic mr);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_rs1_data  = d1;
        bus.id_rs2_data  = d2;
        bus.id_alu_op    = op;
        bus.id_mem_read  = mr;
        bus.id_reg_write = 1'b1;
        bus.id_mem_write = 1'b0;
        bus.id_asel      = 1'b0;
        bus.id_bsel      = 1'b0;
        bus.id_pc        = 32'h40;
        bus.id_imm       = 32'h8;
    endtask

    task automatic rand_inputs();
        bus.id_valid     = ($urandom_range(0, 3) != 0);
        bus.id_pc        = $urandom;
        bus.id_rs1_data  = $urandom;
        bus.id_rs2_data  = $urandom;
        bus.id_imm       = $urandom;
        bus.id_rs1       = RW'($urandom_range(0, 7));
        bus.id_rs2       = RW'($urandom_range(0, 7));
        bus.id_rd        = RW'($urandom_range(0, 7));
        bus.id_alu_op    = OL'($urandom);
        bus.id_asel      = ($urandom_range(0, 3) == 0);
        bus.id_bsel      = ($urandom_range(0, 2) == 0);
        bus.id_reg_write = $urandom_range(0, 1) != 0;
        bus.id_mem_read  = ($urandom_range(0, 2) == 0);
        bus.id_mem_write = ($urandom_range(0, 4) == 0);
        flush            = ($urandom_range(0, 7) == 0);
        mem_rd           = RW'($urandom_range(0, 7));
        mem_reg_write    = $urandom_range(0, 1) != 0;
        mem_result       = $urandom;
        wb_rd            = RW'($urandom_range(0, 7));
        wb_reg_write     = $urandom_range(0, 1) != 0;
        wb_result        = $urandom;
    endtask

    initial begin
        m_ex  = '0;
        m_cnt = 0;

        // Reset held with random ID traffic: everything reads zero.
        rst_n = 1'b0;
        rand_inputs();
        #1;
        tick();
        rand_inputs();
        tick();
        check_all();
        chk("reset_ex_valid", DW'(ex_valid), 32'd0);
        chk("reset_SrcA", SrcA, 32'd0);

        // Release and present ADD x3,x1,x2.
        rst_n = 1'b1;
        flush = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        mem_rd = '0; wb_rd = '0; mem_result = '0; wb_result = '0;
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 4'b0010, 1'b0);
        tick();
        bus.id_valid = 1'b0;
        #1;
        check_all();
        chk("add_SrcA", SrcA, 32'd5);
        chk("add_SrcB", SrcB, 32'd7);
        chk("add_Operation", DW'(Operation), 32'd2);
        chk("add_ex_valid", DW'(ex_valid), 32'd1);

        // MEM/WB forwarding priority on rs1 = x4.
        drive_id(1'b1, 5'd4, 5'd6, 5'd7, 32'd1, 32'd2, 4'd0, 1'b0);
        tick();
        bus.id_valid = 1'b0;
        mem_rd = 5'd4; mem_result = 32'h10; mem_reg_write = 1'b1;
        wb_rd  = 5'd4; wb_result  = 32'h20; wb_reg_write  = 1'b1;
        #1;
        chk("fwd_mem_wins", SrcA, 32'h10);
        mem_reg_write = 1'b0;
        #1;
        chk("fwd_wb", SrcA, 32'h20);
        mem_rd = 5'd0; mem_reg_write = 1'b1; wb_reg_write = 1'b0;
        #1;
        chk("fwd_mem_x0", SrcA, 32'd1);
        check_all();
        mem_reg_write = 1'b0;

        // Load-use: LW x5 then a consumer of x5 via rs2.
        drive_id(1'b1, 5'd1, 5'd9, 5'd5, 32'd0, 32'd0, 4'd0, 1'b1);
        tick();
        drive_id(1'b1, 5'd6, 5'd5, 5'd8, 32'd3, 32'hDEAD, 4'd1, 1'b0);
        #1;
        chk("lu_stall", DW'(load_use_stall), 32'd1);
        check_all();
        tick();
        chk("lu_bubble_valid", DW'(ex_valid), 32'd0);
        chk("lu_stall_drop", DW'(load_use_stall), 32'd0);
        check_all();
        tick();
        wb_rd = 5'd5; wb_reg_write = 1'b1; wb_result = 32'hABC;
        bus.id_valid = 1'b0;
        #1;
        chk("lu_fwd_SrcB", SrcB, 32'hABC);
        chk("lu_enter_valid", DW'(ex_valid), 32'd1);
        check_all();
        wb_reg_write = 1'b0;

        // Flush wins over a load-use stall and does not count as a bubble.
        drive_id(1'b1, 5'd1, 5'd9, 5'd5, 32'd0, 32'd0, 4'd0, 1'b1);
        tick();
        drive_id(1'b1, 5'd6, 5'd5, 5'd8, 32'd3, 32'd4, 4'd1, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush_no_stall", DW'(load_use_stall), 32'd0);
        check_all();
        tick();
        flush = 1'b0;
        bus.id_valid = 1'b0;
        #1;
        chk("flush_bubble", DW'(ex_valid), 32'd0);
        check_all();

        // Operand select: PC and immediate on the ALU, forwarded rs2 on store.
        drive_id(1'b1, 5'd2, 5'd9, 5'd0, 32'd11, 32'd22, 4'd3, 1'b0);
        bus.id_asel = 1'b1; bus.id_bsel = 1'b1; bus.id_mem_write = 1'b1;
        bus.id_pc = 32'h100; bus.id_imm = 32'h4;
        tick();
        bus.id_valid = 1'b0;
        mem_rd = 5'd9; mem_reg_write = 1'b1; mem_result = 32'h55;
        #1;
        chk("sel_SrcA", SrcA, 32'h100);
        chk("sel_SrcB", SrcB, 32'h4);
        chk("sel_store", ex_store_data, 32'h55);
        check_all();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            #1;
            check_all();
            tick();
            check_all();
        end

        // Reset asserted during an active stall clears outputs immediately.
        flush = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        drive_id(1'b1, 5'd1, 5'd9, 5'd5, 32'd0, 32'd0, 4'd0, 1'b1);
        tick();
        drive_id(1'b1, 5'd5, 5'd2, 5'd8, 32'd3, 32'd4, 4'd1, 1'b0);
        #1;
        chk("mid_stall_set", DW'(load_use_stall), 32'd1);
        rst_n = 1'b0;
        m_ex  = '0;
        m_cnt = 0;
        #1;
        chk("rst_stall", DW'(load_use_stall), 32'd0);
        chk("rst_ex_valid", DW'(ex_valid), 32'd0);
        check_all();
        tick();
        rst_n = 1'b1;
        tick();
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-select stage that sits directly upstream of the ALU. Each cycle it captures one decoded instruction, then in the EX cycle resolves forwarding from the MEM and WB stages. It drives `SrcA`, `SrcB` and `Operation` into the ALU. It also detects load-use hazards and inserts bubbles so the rest of the pipeline sees correct operands.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width
- OPCODE_LENGTH, 4, ALU operation code width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_pc  in  DATA_WIDTH  instruction PC
- id_rs1_data, id_rs2_data, id_imm  in  DATA_WIDTH  register-file reads and immediate
- id_rs1, id_rs2, id_rd  in  REG_ADDR_WIDTH  source and destination indices
- id_alu_op  in  OPCODE_LENGTH  ALU operation code
- id_asel  in  1  0: A = rs1 operand, 1: A = PC
- id_bsel  in  1  0: B = rs2 operand, 1: B = immediate
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- flush  in  1  kill the instruction entering EX (taken branch or jump)
- mem_rd  in  REG_ADDR_WIDTH; mem_reg_write  in  1; mem_result  in  DATA_WIDTH  EX/MEM forwarding source
- wb_rd  in  REG_ADDR_WIDTH; wb_reg_write  in  1; wb_result  in  DATA_WIDTH  MEM/WB forwarding source
- load_use_stall  out  1  upstream must hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- SrcA, SrcB  out  DATA_WIDTH  ALU operands
- Operation  out  OPCODE_LENGTH  ALU operation code
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value, used by stores
- ex_rd  out  REG_ADDR_WIDTH; ex_reg_write, ex_mem_read, ex_mem_write  out  1  passed downstream

## Operation
- **Register update.** On every rising edge, the register loads one of two things:
  - Bubble if `flush | load_use_stall | !id_valid`.
  - Otherwise, all `id_*` fields.
- **Bubble contents.** `ex_valid` = 0 and every control bit = 0. `ex_rd`, registered rs1/rs2 indices, data fields and `Operation` are all 0.
- **Forwarding.** Combinational, evaluated on the registered rs1 and rs2 independently:
  - If `mem_reg_write`, `mem_rd` != 0 and `mem_rd` == rs, use `mem_result`.
  - Else if `wb_reg_write`, `wb_rd` != 0 and `wb_rd` == rs, use `wb_result`.
  - Else use the registered register-file value.
  - x0 is never forwarded.
- **Operand select.**
  - `SrcA` = `asel` ? pc : fwd_rs1.
  - `SrcB` = `bsel` ? imm : fwd_rs2.
  - `ex_store_data` = fwd_rs2, regardless of `bsel`.
  - `Operation` = registered `alu_op`.
- **Load-use hazard.** `load_use_stall` = `ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (id_rs1 == ex_rd | id_rs2 == ex_rd) & !flush`.
- **Stall behaviour.** A stall inserts exactly one bubble. On the next cycle the load has left EX, so the stall drops and the held instruction enters. Its operand is then forwarded from MEM/WB.
- **Flush vs. stall.** `flush` has priority: it forces a bubble and suppresses `load_use_stall`.
- **Arithmetic.** No arithmetic is performed here; all widths are pass-through.

## Timing
- Latency: ID to EX outputs is 1 cycle.
- Forwarding and operand muxes are combinational within the EX cycle, with no added latency.
- `load_use_stall` is combinational from `id_*` and the EX register, valid in the same cycle.
- Reset: `rst_n` low clears the register immediately, without waiting for a clock edge. Every output then reads 0, including `load_use_stall` = 0.
- Reset deasserting mid-stream: the first edge after release captures `id_*` normally. An instruction in flight at the time of reset is lost.
- Simultaneous MEM and WB match on the same rs: MEM wins (it is the younger result).
- A back-to-back load followed by a dependent instruction always costs exactly 1 bubble. It never costs 2.

## Configuration
- Macro: `ID_EX_PERF_EN`.
- **Defined:** adds output `bubble_cnt` (32 bits).
  - Increments on each edge where a load-use bubble is inserted. Flush bubbles do not count.
  - Saturates at 0xFFFFFFFF.
  - Cleared by `rst_n`.
- **Undefined:** the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Reset.** Hold `rst_n` = 0 with random `id_*` inputs → all outputs 0. Release, present ADD x3,x1,x2 with rs1 = 5, rs2 = 7, `id_alu_op` = 0010 → next cycle `SrcA` = 5, `SrcB` = 7, `Operation` = 0010, `ex_valid` = 1.
- **MEM/WB forwarding.** EX holds rs1 = x4 with stale value 1. Set `mem_rd` = 4, `mem_result` = 0x10 and `wb_rd` = 4, `wb_result` = 0x20, both write-enabled → `SrcA` = 0x10. Deassert `mem_reg_write` → `SrcA` = 0x20. Set `mem_rd` = 0 with write enabled → no forward from MEM.
- **Load-use.** EX holds LW into x5. `id_rs2` = 5, `id_valid` = 1 → `load_use_stall` = 1 for 1 cycle and the next EX is a bubble (`ex_valid` = 0). The following cycle the instruction enters, and `SrcB` equals `wb_result` via forwarding.
- **Flush vs. stall.** Create the load-use condition above and assert `flush` in the same cycle → `load_use_stall` = 0, next EX is a bubble. With `ID_EX_PERF_EN` defined, `bubble_cnt` is unchanged.
- **Operand select.** `asel` = 1, `bsel` = 1, `id_pc` = 0x100, `id_imm` = 0x4, rs2 forwarded value 0x55 → `SrcA` = 0x100, `SrcB` = 0x4, `ex_store_data` = 0x55.
- **Reset mid-stall.** Pull `rst_n` low during an active stall → `load_use_stall`, `ex_valid` and `bubble_cnt` all read 0 without waiting for a clock edge.
